// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg
//   Shared definitions for the SPI command decoder: opcode values, header
//   field positions, FSM state encoding, the flag-clear address and small
//   header-field extraction helpers.
package spi_cmd_pkg;

  localparam int HDR_W = 16;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_STRM = 2'b11;

  localparam int HDR_OP_MSB   = 15;
  localparam int HDR_OP_LSB   = 14;
  localparam int HDR_ADDR_MSB = 13;
  localparam int HDR_ADDR_LSB = 8;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 0;

  localparam logic [5:0] ADDR_CLR = 6'd63;

  // The state code is also reported in bits [13:12] of the status word.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_STRM = 2'd3
  } state_t;

  function automatic logic [1:0] hdr_opcode(input logic [HDR_W-1:0] w);
    return w[HDR_OP_MSB:HDR_OP_LSB];
  endfunction

  function automatic logic [5:0] hdr_addr(input logic [HDR_W-1:0] w);
    return w[HDR_ADDR_MSB:HDR_ADDR_LSB];
  endfunction

  function automatic logic [7:0] hdr_len(input logic [HDR_W-1:0] w);
    return w[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

endpackage

// File: rtl/spi_sample_fifo.sv
// spi_sample_fifo
//   Synchronous FIFO for ECG samples. A push while full is accepted only if a
//   pop happens in the same cycle.
//   Ports: wclk, rst_n (async, active-low), push/wdata, pop/rdata (head),
//          full, empty, level (occupancy).
module spi_sample_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          wclk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + LW'(1);
      else if (do_pop && !do_push) count <= count - LW'(1);
    end
  end

  always_ff @(posedge wclk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder
//   Parses SPI words into config-register writes, reads, or sample streams.
//   Ports: wclk, rst_n (async, active-low), cs_n (high aborts), rx_vld/rx_word
//          from the SPI slave, tx_word back to it, cfg_regs (flattened
//          register file), cfg_wr (per-register write pulse), smp_data/smp_vld/
//          smp_rdy (sample FIFO head), fifo_level, ovf_flag, err_flag (sticky).
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int  SPI_DW     = 16,
  parameter int  NREG       = 8,
  parameter int  FIFO_DEPTH = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   wclk,
  input  logic                   rst_n,
  input  logic                   cs_n,
  input  logic                   rx_vld,
  input  logic [SPI_DW-1:0]      rx_word,
  output logic [SPI_DW-1:0]      tx_word,
  output logic [NREG*SPI_DW-1:0] cfg_regs,
  output logic [NREG-1:0]        cfg_wr,
  output logic [SPI_DW-1:0]      smp_data,
  output logic                   smp_vld,
  input  logic                   smp_rdy,
  output logic [LVL_W-1:0]       fifo_level,
  output logic                   ovf_flag,
  output logic                   err_flag
);

  localparam int RA      = (NREG > 1) ? $clog2(NREG) : 1;
  localparam bit HAS_CLR = (NREG < 64);

  state_t              state_q, state_d;
  logic [RA-1:0]       ptr_q, ptr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                extra_q, extra_d;
  logic                bad_q, bad_d;
  logic                clr_q, clr_d;
  logic [SPI_DW-1:0]   rd_q, rd_d;
  logic [SPI_DW-1:0]   regs [NREG];
  logic [NREG-1:0]     cfg_wr_q;
  logic                ovf_q, err_q;

  logic                reg_we, set_err, clr_flags, fifo_push;
  logic                fifo_pop, fifo_full, fifo_empty, drop;
  logic [5:0]          h_addr;
  logic [RA-1:0]       h_idx;
  logic                h_in_range, h_is_clr;
  logic [HDR_W-1:0]    status_word;

  assign h_addr     = hdr_addr(rx_word[HDR_W-1:0]);
  assign h_idx      = h_addr[RA-1:0];
  assign h_in_range = (int'(h_addr) < NREG);
  assign h_is_clr   = HAS_CLR && (h_addr == ADDR_CLR);

  assign fifo_pop = smp_rdy && !fifo_empty;
  assign drop     = fifo_push && fifo_full && !fifo_pop;

  assign status_word = {ovf_q, err_q, 2'(state_q), 12'(fifo_level)};
  // In RD the pre-fetched register is presented; otherwise live status.
  assign tx_word     = (state_q == ST_RD) ? rd_q : SPI_DW'(status_word);

  assign cfg_wr   = cfg_wr_q;
  assign smp_vld  = !fifo_empty;
  assign ovf_flag = ovf_q;
  assign err_flag = err_q;

  always_comb begin
    for (int i = 0; i < NREG; i++) cfg_regs[i*SPI_DW +: SPI_DW] = regs[i];
  end

  // RD runs one word longer than its length field (read latency), tracked
  // by extra_q so cnt stays 8 bits even at len = 255.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    extra_d   = extra_q;
    bad_d     = bad_q;
    clr_d     = clr_q;
    rd_d      = rd_q;
    reg_we    = 1'b0;
    set_err   = 1'b0;
    clr_flags = 1'b0;
    fifo_push = 1'b0;

    if (cs_n) begin
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
        set_err = 1'b1;
      end
    end else if (rx_vld) begin
      case (state_q)
        ST_IDLE: begin
          ptr_d   = h_idx;
          cnt_d   = hdr_len(rx_word[HDR_W-1:0]);
          extra_d = 1'b1;
          bad_d   = !h_in_range;
          clr_d   = h_is_clr;
          case (hdr_opcode(rx_word[HDR_W-1:0]))
            OP_WR: begin
              state_d = ST_WR;
              set_err = !h_in_range && !h_is_clr;
            end
            OP_RD: begin
              state_d = ST_RD;
              set_err = !h_in_range;
              rd_d    = h_in_range ? regs[h_idx] : '0;
              ptr_d   = h_idx + RA'(1);
            end
            OP_STRM: state_d = ST_STRM;
            default: ;
          endcase
        end
        ST_WR: begin
          if (clr_q)       clr_flags = rx_word[0];
          else if (!bad_q) reg_we    = 1'b1;
          ptr_d = ptr_q + RA'(1);
          if (cnt_q == 8'd0) state_d = ST_IDLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
        ST_RD: begin
          rd_d  = bad_q ? '0 : regs[ptr_q];
          ptr_d = ptr_q + RA'(1);
          if (cnt_q != 8'd0) cnt_d   = cnt_q - 8'd1;
          else if (extra_q)  extra_d = 1'b0;
          else               state_d = ST_IDLE;
        end
        ST_STRM: begin
          fifo_push = 1'b1;
          if (cnt_q == 8'd0) state_d = ST_IDLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      extra_q <= 1'b0;
      bad_q   <= 1'b0;
      clr_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      extra_q <= extra_d;
      bad_q   <= bad_d;
      clr_q   <= clr_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      cfg_wr_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cfg_wr_q <= '0;
      if (reg_we) begin
        regs[ptr_q]     <= rx_word;
        cfg_wr_q[ptr_q] <= 1'b1;
      end
      if (clr_flags) begin
        ovf_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        if (set_err) err_q <= 1'b1;
        if (drop)    ovf_q <= 1'b1;
      end
    end
  end

  spi_sample_fifo #(
    .DW    (SPI_DW),
    .DEPTH (FIFO_DEPTH),
    .LW    (LVL_W)
  ) u_fifo (
    .wclk  (wclk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (rx_word),
    .pop   (fifo_pop),
    .rdata (smp_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder
//   Drives SPI words into spi_cmd_decoder and compares every observable
//   output against a transaction-level model (register array, sample queue,
//   two sticky flags).
module tb_spi_cmd_decoder;

  localparam int NREG       = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int LW         = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] opNop  = 2'd0;
  localparam logic [1:0] opWr   = 2'd1;
  localparam logic [1:0] opRd   = 2'd2;
  localparam logic [1:0] opStrm = 2'd3;

  logic                 wclk = 1'b0;
  logic                 rst_n;
  logic                 cs_n;
  logic                 rx_vld;
  logic [15:0]          rx_word;
  logic [15:0]          tx_word;
  logic [NREG*16-1:0]   cfg_regs;
  logic [NREG-1:0]      cfg_wr;
  logic [15:0]          smp_data;
  logic                 smp_vld;
  logic                 smp_rdy;
  logic [LW-1:0]        fifo_level;
  logic                 ovf_flag;
  logic                 err_flag;

  spi_cmd_decoder #(.SPI_DW(16), .NREG(NREG), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .wclk       (wclk),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .rx_vld     (rx_vld),
    .rx_word    (rx_word),
    .tx_word    (tx_word),
    .cfg_regs   (cfg_regs),
    .cfg_wr     (cfg_wr),
    .smp_data   (smp_data),
    .smp_vld    (smp_vld),
    .smp_rdy    (smp_rdy),
    .fifo_level (fifo_level),
    .ovf_flag   (ovf_flag),
    .err_flag   (err_flag)
  );

  always #5 wclk = ~wclk;

  // Reference model state
  logic [15:0] mRegs [NREG];
  logic [15:0] mFifo [$];
  logic [15:0] stimData [$];
  logic        mOvf;
  logic        mErr;
  int          testsRun = 0;
  int          testsFailed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] mStatus(input logic [1:0] st);
    return {mOvf, mErr, st, 12'(mFifo.size())};
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NREG; i++) mRegs[i] = 16'h0;
    mFifo.delete();
    mOvf = 1'b0;
    mErr = 1'b0;
  endfunction

  // One SPI word: rx_vld for one cycle, optionally with smp_rdy. Returns what
  // the slave would load at that boundary and the cfg_wr seen one cycle later.
  task automatic applyStimulus(input logic [15:0] w, input bit rdy,
                               output logic [15:0] txLoad, output logic [NREG-1:0] wrSeen);
    @(negedge wclk);
    rx_word = w;
    rx_vld  = 1'b1;
    smp_rdy = rdy;
    txLoad  = tx_word;
    if (rdy && mFifo.size() > 0) begin
      checkOutput("pop head", 32'(smp_data), 32'(mFifo[0]));
      void'(mFifo.pop_front());
    end
    @(negedge wclk);
    wrSeen  = cfg_wr;
    rx_vld  = 1'b0;
    smp_rdy = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    @(negedge wclk);
    checkOutput({tag, " status"}, 32'(tx_word), 32'(mStatus(2'd0)));
    checkOutput({tag, " level"}, 32'(fifo_level), 32'(mFifo.size()));
    checkOutput({tag, " smp_vld"}, 32'(smp_vld), 32'(mFifo.size() > 0));
    checkOutput({tag, " ovf"}, 32'(ovf_flag), 32'(mOvf));
    checkOutput({tag, " err"}, 32'(err_flag), 32'(mErr));
    checkOutput({tag, " cfg_wr"}, 32'(cfg_wr), 32'(0));
    for (int i = 0; i < NREG; i++)
      checkOutput($sformatf("%s reg%0d", tag, i), 32'(cfg_regs[i*16 +: 16]), 32'(mRegs[i]));
  endtask

  // cs_n rises together with a word; the word must be discarded.
  task automatic doAbort();
    @(negedge wclk);
    cs_n    = 1'b1;
    rx_vld  = 1'b1;
    rx_word = 16'($urandom);
    @(negedge wclk);
    rx_vld = 1'b0;
    mErr   = 1'b1;
    checkOutput("abort status", 32'(tx_word), 32'(mStatus(2'd0)));
    cs_n = 1'b0;
  endtask

  task automatic drainFifo();
    int guard;
    guard = 0;
    @(negedge wclk);
    while (mFifo.size() > 0 && guard < 64) begin
      checkOutput("drain vld", 32'(smp_vld), 32'(1));
      checkOutput("drain data", 32'(smp_data), 32'(mFifo[0]));
      smp_rdy = 1'b1;
      @(negedge wclk);
      void'(mFifo.pop_front());
      guard++;
    end
    smp_rdy = 1'b0;
    checkOutput("drain empty", 32'(smp_vld), 32'(0));
  endtask

  // rdyMode: 0 never pop, 1 pop on every data word, 2 random pops.
  task automatic runTxn(input logic [1:0] op, input logic [5:0] addr, input logic [7:0] len,
                        input int abortAt, input int rdyMode);
    logic [15:0]     tx, w, expTx;
    logic [NREG-1:0] wr, expWr;
    int              nWords, a;
    bit              rdy, inRange;
    inRange = int'(addr) < NREG;
    expTx   = mStatus(2'd0);
    rdy     = (rdyMode == 2) && ($urandom_range(1) == 1);
    applyStimulus({op, addr, len}, rdy, tx, wr);
    checkOutput("hdr status", 32'(tx), 32'(expTx));
    checkOutput("hdr cfg_wr", 32'(wr), 32'(0));
    if (op == opWr && !inRange && addr != 6'd63) mErr = 1'b1;
    if (op == opRd && !inRange) mErr = 1'b1;
    nWords = (op == opNop) ? 0 : (op == opRd) ? int'(len) + 2 : int'(len) + 1;
    a = int'(addr);
    for (int k = 1; k <= nWords; k++) begin
      if (k == abortAt) begin
        doAbort();
        break;
      end
      w     = (stimData.size() > 0) ? stimData.pop_front() : 16'($urandom);
      rdy   = (rdyMode == 1) || (rdyMode == 2 && $urandom_range(1) == 1);
      expTx = (op == opRd) ? (inRange ? mRegs[(a + k - 1) % NREG] : 16'h0) : mStatus(op);
      expWr = '0;
      applyStimulus(w, rdy, tx, wr);
      if (op == opWr) begin
        if (addr == 6'd63) begin
          if (w[0]) begin
            mOvf = 1'b0;
            mErr = 1'b0;
          end
        end else if (inRange) begin
          mRegs[a] = w;
          expWr    = NREG'(1) << a;
          a        = (a + 1) % NREG;
        end
      end else if (op == opStrm) begin
        if (mFifo.size() < FIFO_DEPTH) mFifo.push_back(w);
        else mOvf = 1'b1;
      end
      checkOutput($sformatf("op%0d w%0d tx", op, k), 32'(tx), 32'(expTx));
      checkOutput($sformatf("op%0d w%0d cfg_wr", op, k), 32'(wr), 32'(expWr));
    end
    checkIdle($sformatf("op%0d end", op));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0]     tx;
    logic [NREG-1:0] wr;
    logic [5:0]      rAddr;
    logic [1:0]      rOp;
    int              r;

    rst_n = 1'b0; cs_n = 1'b1; rx_vld = 1'b0; rx_word = 16'h0; smp_rdy = 1'b0;
    modelReset();
    repeat (2) @(negedge wclk);
    rst_n = 1'b1;
    cs_n  = 1'b0;
    checkIdle("reset");

    // Write regs 2..4, then read them back.
    stimData = '{16'h1111, 16'h2222, 16'h3333};
    runTxn(opWr, 6'd2, 8'd2, 0, 0);
    runTxn(opRd, 6'd2, 8'd1, 0, 0);

    // Address wrap, out-of-range write, flag clear.
    stimData = '{16'hAAAA, 16'hBBBB};
    runTxn(opWr, 6'd7, 8'd1, 0, 0);
    runTxn(opWr, 6'd10, 8'd0, 0, 0);
    stimData = '{16'h0001};
    runTxn(opWr, 6'd63, 8'd0, 0, 0);

    // Overflow: 18 samples into a 16-deep FIFO, then drain in order.
    for (int i = 0; i < 18; i++) stimData.push_back(16'(i));
    runTxn(opStrm, 6'd0, 8'd17, 0, 0);
    drainFifo();

    // Abort mid-stream, then clear flags.
    stimData = '{16'h0001};
    runTxn(opWr, 6'd63, 8'd0, 0, 0);
    runTxn(opStrm, 6'd0, 8'd4, 3, 0);
    stimData = '{16'h0001};
    runTxn(opWr, 6'd63, 8'd0, 0, 0);
    drainFifo();

    // Full FIFO with simultaneous push and pop: accepted, no overflow.
    for (int i = 0; i < 16; i++) stimData.push_back(16'(100 + i));
    runTxn(opStrm, 6'd0, 8'd15, 0, 0);
    stimData = '{16'h00C8};
    runTxn(opStrm, 6'd0, 8'd0, 0, 1);
    drainFifo();

    // Longest transaction: len = 255.
    runTxn(opWr, 6'd0, 8'd255, 0, 2);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      rOp = 2'($urandom_range(3));
      r   = $urandom_range(9);
      rAddr = (r == 9) ? 6'd63 : (r == 8) ? 6'($urandom_range(8, 62)) : 6'(r);
      runTxn(rOp, rAddr, 8'($urandom_range(5)),
             ($urandom_range(7) == 0) ? $urandom_range(1, 6) : 0, 2);
      if ($urandom_range(3) == 0) drainFifo();
    end
    drainFifo();

    // Asynchronous reset in the middle of a stream.
    applyStimulus(16'hC009, 1'b0, tx, wr);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(16'(16'h0500 + i), 1'b0, tx, wr);
      mFifo.push_back(16'(16'h0500 + i));
    end
    checkOutput("pre-reset level", 32'(fifo_level), 32'(5));
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst level", 32'(fifo_level), 32'(0));
    checkOutput("rst smp_vld", 32'(smp_vld), 32'(0));
    checkOutput("rst tx_word", 32'(tx_word), 32'(0));
    for (int i = 0; i < NREG; i++)
      checkOutput($sformatf("rst reg%0d", i), 32'(cfg_regs[i*16 +: 16]), 32'(0));
    @(negedge wclk);
    rst_n = 1'b1;
    checkIdle("post-reset");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
